hex_display_scan: RTL and testbench

//  Time-multiplexed 8-digit hex display driver, downstream of the pipelined CPU top.

---
 rtl/hex_display_scan.sv | 113 +++++++++++
 tb/tb_hex_display_scan.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display driver: scans DIGITS nibbles of a shadowed word onto one 7-seg bus.
// Latency: outputs are registered, one cycle behind the slot counter / digit index state.
// Backpressure: none; load is always accepted, and a new word becomes visible only at a frame boundary.
module hex_display_scan #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   word,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]         div_cnt_q, div_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  fs_q, fs_d;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic [IW-1:0]         lead;
  logic [3:0]            nibble;
  logic                  dark;

  // Active-low gfedcba glyph for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0011000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
    endcase
  endfunction

  // Highest nonzero nibble of the displayed word; digits above it are leading zeros.
  always_comb begin
    lead = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (shadow_q[4*i +: 4] != 4'd0) lead = IW'(i);
    end
  end

  // Next-state: slot prescaler, digit index, load capture and frame-boundary shadow update.
  always_comb begin
    slot_wrap  = (div_cnt_q == DIV_MAX);
    frame_wrap = slot_wrap && (idx_q == IDX_MAX);
    div_cnt_d  = slot_wrap ? '0 : div_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_wrap) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    pending_d  = load ? word : pending_q;
    // The shadow takes the pending value from before this edge, so a load
    // coinciding with the frame wrap waits one more frame.
    shadow_d   = frame_wrap ? pending_q : shadow_q;
    nibble     = shadow_q[{idx_q, 2'b00} +: 4];
    dark       = (div_cnt_q < GUARD_C) || (blank_lz && (idx_q > lead));
    an_d       = dark ? '1 : ~(DIGITS'(1) << idx_q);
    seg_d      = dark ? 7'b1111111 : hex7(nibble);
    fs_d       = frame_wrap;
  end

  // State and registered outputs; reset forces the display dark without a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      pending_q <= '0;
      shadow_q  <= '0;
      seg_q     <= 7'b1111111;
      an_q      <= '1;
      fs_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fs_q      <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with SCAN_DIV=4, GUARD=1, DIGITS=8.
// Expected glyphs and lit-digit masks are hand-computed per table entry.
// Outputs are sampled on the falling clock edge.
module tb_hex_display_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] word  = '0;
  logic        load  = 1'b0;
  logic        blank_lz = 1'b1;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        frame_start;

  int passed = 0;
  int total  = 0;

  hex_display_scan #(.DIGITS(8), .SCAN_DIV(4), .GUARD(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .word        (word),
    .load        (load),
    .blank_lz    (blank_lz),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]     w;
    logic            blz;
    logic [7:0]      lit;
    logic [7:0][6:0] sg;   // sg[i] = glyph of digit i
  } vec_t;

  localparam logic [6:0] Z = 7'b1000000;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Advance one cycle and check the output belonging to frame slot k of entry e.
  task automatic check_cycle(input int e, input int k, input string tag);
    int d;
    logic [14:0] exp;
    @(negedge clock);
    d = k / 4;
    if ((k % 4) == 0 || !tbl[e].lit[d]) exp = {8'hFF, 7'h7F};
    else exp = {~(8'h01 << d), tbl[e].sg[d]};
    chk($sformatf("%s e%0d slot%0d", tag, e, k), {17'd0, an, seg}, {17'd0, exp});
  endtask

  task automatic check_frame(input int e, input string tag);
    for (int k = 0; k < 32; k++) check_cycle(e, k, tag);
  endtask

  // Returns at the falling edge where frame_start is high (checks current value first).
  task automatic wait_fs(input string tag);
    int n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (frame_start !== 1'b1) begin
      total++;
      $display("FAIL %s: frame_start timeout got 0 expected 1", tag);
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{32'h000000A3, 1'b0, 8'hFF, {Z, Z, Z, Z, Z, Z, 7'b0001000, 7'b0110000}};
    tbl[1] = '{32'h000000A3, 1'b1, 8'h03, {Z, Z, Z, Z, Z, Z, 7'b0001000, 7'b0110000}};
    tbl[2] = '{32'h12345678, 1'b0, 8'hFF, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
    tbl[3] = '{32'hDEADBEEF, 1'b0, 8'hFF, {7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001,
                                           7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}};
    tbl[4] = '{32'h00F00000, 1'b1, 8'h3F, {Z, Z, 7'b0001110, Z, Z, Z, Z, Z}};
    tbl[5] = '{32'h00000000, 1'b1, 8'h01, {Z, Z, Z, Z, Z, Z, Z, Z}};

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rst_hold", {17'd0, an, seg}, {17'd0, 8'hFF, 7'h7F});
      chk("rst_fs", {31'd0, frame_start}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("first_edge", {17'd0, an, seg}, {17'd0, 8'hFF, 7'h7F});
    n = 1;
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("fs_after_release", n, 32'd32);

    // Freshly reset shadow is zero: only digit 0 lit with blanking on.
    check_frame(5, "reset_frame");

    // Table-driven: load right after a frame start, verify the whole next frame.
    for (int e = 0; e < 6; e++) begin
      wait_fs("tbl");
      blank_lz = tbl[e].blz;
      word = tbl[e].w;
      load = 1'b1;
      @(negedge clock);
      load = 1'b0;
      wait_fs("tbl");
      check_frame(e, "tbl");
    end

    // Two loads in one frame: old value stays up, only the last load appears next frame.
    wait_fs("multi");
    for (int k = 0; k < 32; k++) begin
      if (k == 5)  begin word = 32'h12345678; load = 1'b1; end
      if (k == 20) begin word = 32'hDEADBEEF; load = 1'b1; end
      check_cycle(5, k, "multi_old");
      load = 1'b0;
    end
    wait_fs("multi");
    check_frame(3, "multi_new");

    // Load on the frame-wrap edge: shown only from the frame after next.
    for (int k = 0; k < 32; k++) begin
      if (k == 31) begin word = 32'h12345678; load = 1'b1; end
      check_cycle(3, k, "wrapld_pre");
      load = 1'b0;
    end
    wait_fs("wrapld");
    check_frame(3, "wrapld_hold");
    wait_fs("wrapld");
    check_frame(2, "wrapld_new");

    // Asynchronous reset at idx=5, div_cnt=2.
    wait_fs("arst");
    repeat (22) @(negedge clock);
    chk("pre_arst", {17'd0, an, seg}, {17'd0, 8'hDF, 7'b0110000});
    #2 reset = 1'b1;
    #1 chk("arst_dark", {17'd0, an, seg}, {17'd0, 8'hFF, 7'h7F});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    while (an === 8'hFF && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("first_lit_after_arst", {24'd0, an}, {24'd0, 8'hFE});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
